controlador_deslocamento: RTL and testbench

//  Select-code generator and register for the bidirectional shift datapath. Accepts
//  one command (load, shift right-to-left, shift left-to-right), then drives the
//  {ch1,ch0} select code and the bit-cell enable cycle by cycle until done.

---
 rtl/controlador_deslocamento_pkg.sv | 21 ++
 rtl/controlador_deslocamento_celula.sv | 35 +++
 rtl/controlador_deslocamento.sv | 132 +++++++++++++
 tb/tb_controlador_deslocamento.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/controlador_deslocamento_pkg.sv
// rtl/controlador_deslocamento_pkg.sv - mode codes and FSM state encodings for the shift controller
package controlador_deslocamento_pkg;

    typedef enum logic [1:0] {
        MODO_CARGA   = 2'b00,
        MODO_DIR_ESQ = 2'b01,
        MODO_ESQ_DIR = 2'b10,
        MODO_NENHUM  = 2'b11
    } modo_t;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        CARGA   = 2'b01,
        DESLOCA = 2'b10,
        FIM     = 2'b11
    } estado_t;

    // Select code presented to the bit cells whenever no update is in progress
    localparam logic [1:0] SEL_REPOUSO = 2'b11;

endpackage

// File: rtl/controlador_deslocamento_celula.sv
// rtl/controlador_deslocamento_celula.sv - one register bit with load/right/left neighbour select
module celula_deslocamento
    import controlador_deslocamento_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       habilita,
    input  logic [1:0] sel,
    input  logic       carga,
    input  logic       viz_dir,
    input  logic       viz_esq,
    output logic       q
);

    logic d;

    always_comb begin
        d = q;
        case (sel)
            MODO_CARGA:   d = carga;
            MODO_DIR_ESQ: d = viz_dir;
            MODO_ESQ_DIR: d = viz_esq;
            default:      d = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else if (habilita) begin
            q <= d;
        end
    end

endmodule

// File: rtl/controlador_deslocamento.sv
// rtl/controlador_deslocamento.sv - command FSM, step counter and register for the bidirectional shifter
module controlador_deslocamento
    import controlador_deslocamento_pkg::*;
#(
    parameter int LARGURA = 8,
    parameter int CONT_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [1:0]         modo,
    input  logic [CONT_W-1:0]  passos,
    input  logic [LARGURA-1:0] valor_carga,
    input  logic               entrada_serial,
    output logic               pronto,
    output logic               ch1,
    output logic               ch0,
    output logic               habilita,
    output logic [LARGURA-1:0] valor,
    output logic               saida_serial,
    output logic               concluido,
    output logic               erro_modo
);

    estado_t             estado, prox;
    logic [1:0]          modo_lat;
    logic [CONT_W-1:0]   contador;
    logic [LARGURA-1:0]  carga_lat;
    logic [1:0]          sel;
    logic                aceita;

    assign aceita = (estado == OCIOSO) && iniciar;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox;
        end
    end

    always_comb begin
        prox      = estado;
        pronto    = 1'b0;
        sel       = SEL_REPOUSO;
        habilita  = 1'b0;
        concluido = 1'b0;
        case (estado)
            OCIOSO: begin
                pronto = 1'b1;
                if (iniciar) begin
                    case (modo)
                        MODO_CARGA:   prox = CARGA;
                        MODO_DIR_ESQ,
                        MODO_ESQ_DIR: prox = (passos != '0) ? DESLOCA : FIM;
                        default:      prox = OCIOSO;
                    endcase
                end
            end
            CARGA: begin
                sel      = MODO_CARGA;
                habilita = 1'b1;
                prox     = FIM;
            end
            DESLOCA: begin
                sel      = modo_lat;
                habilita = 1'b1;
                if (contador == CONT_W'(1)) begin
                    prox = FIM;
                end
            end
            FIM: begin
                concluido = 1'b1;
                prox      = OCIOSO;
            end
            default: prox = OCIOSO;
        endcase
    end

    assign ch1 = sel[1];
    assign ch0 = sel[0];

    // Command operands are captured on accept so the inputs may change while busy
    always_ff @(posedge clk) begin
        if (reset) begin
            modo_lat     <= '0;
            contador     <= '0;
            carga_lat    <= '0;
            saida_serial <= 1'b0;
            erro_modo    <= 1'b0;
        end else begin
            erro_modo <= aceita && (modo == MODO_NENHUM);
            if (aceita) begin
                modo_lat  <= modo;
                carga_lat <= valor_carga;
                contador  <= passos;
            end
            if (estado == DESLOCA) begin
                contador     <= contador - CONT_W'(1);
                saida_serial <= (modo_lat == MODO_DIR_ESQ) ? valor[LARGURA-1] : valor[0];
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < LARGURA; i++) begin : g_celula
            logic viz_dir, viz_esq;
            if (i == 0) begin : g_lsb
                assign viz_dir = entrada_serial;
            end else begin : g_dir
                assign viz_dir = valor[i-1];
            end
            if (i == LARGURA-1) begin : g_msb
                assign viz_esq = entrada_serial;
            end else begin : g_esq
                assign viz_esq = valor[i+1];
            end
            celula_deslocamento u_celula (
                .clk      (clk),
                .reset    (reset),
                .habilita (habilita),
                .sel      (sel),
                .carga    (carga_lat[i]),
                .viz_dir  (viz_dir),
                .viz_esq  (viz_esq),
                .q        (valor[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_controlador_deslocamento.sv
// tb/tb_controlador_deslocamento.sv - table, hand-sequence and random checks for controlador_deslocamento
module tb_controlador_deslocamento;

    logic       clk = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [1:0] modo;
    logic [3:0] passos;
    logic [7:0] valor_carga;
    logic       entrada_serial;
    logic       pronto, ch1, ch0, habilita, saida_serial, concluido, erro_modo;
    logic [7:0] valor;

    int n_vec = 0;
    int n_mis = 0;
    logic [7:0] vm;
    logic       sm;

    always #5 clk = ~clk;

    controlador_deslocamento #(.LARGURA(8), .CONT_W(4)) dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .modo(modo), .passos(passos),
        .valor_carga(valor_carga), .entrada_serial(entrada_serial), .pronto(pronto),
        .ch1(ch1), .ch0(ch0), .habilita(habilita), .valor(valor),
        .saida_serial(saida_serial), .concluido(concluido), .erro_modo(erro_modo)
    );

    typedef struct {
        logic [1:0] m;
        logic [3:0] n;
        logic [7:0] c;
        logic       s;
        logic [7:0] ev;
        logic       es;
        int         eb;
    } vetor_t;

    vetor_t tab[8];

    task automatic chk(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
        n_vec++;
        if (obtido !== esperado) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, obtido, esperado, $time);
        end
    endtask

    // Register after n steps of a command, from shift arithmetic on a widened word
    function automatic logic [7:0] modelo_valor(input logic [7:0] v, input logic [1:0] m,
                                                input logic s, input int n, input logic [7:0] c);
        logic [31:0] w;
        if (n == 0) return v;
        case (m)
            2'b00:   return c;
            2'b01: begin
                w = ({24'b0, v} << n) | (s ? ((32'h1 << n) - 1) : 32'h0);
                return w[7:0];
            end
            2'b10: begin
                w = ({24'b0, v} >> n) | (s ? (32'hFF & ~(32'hFF >> n)) : 32'h0);
                return w[7:0];
            end
            default: return v;
        endcase
    endfunction

    function automatic logic modelo_saida(input logic [7:0] v, input logic [1:0] m,
                                          input logic s, input int n, input logic prev);
        if (n == 0 || m == 2'b00 || m == 2'b11) return prev;
        if (n > 8) return s;
        return (m == 2'b01) ? v[8-n] : v[n-1];
    endfunction

    task automatic executa(input logic [1:0] m, input logic [3:0] n, input logic [7:0] c,
                           input logic s, output int busy);
        int n_ef, e_busy, conc, err, passo;
        bit ok;
        logic [7:0] v0;
        n_ef   = (m == 2'b00) ? 1 : (m == 2'b11) ? 0 : int'(n);
        e_busy = (m == 2'b00) ? 2 : (m == 2'b11) ? 0 : int'(n) + 1;
        v0 = vm;
        @(negedge clk);
        iniciar = 1'b1; modo = m; passos = n; valor_carga = c; entrada_serial = s;
        @(posedge clk);
        #1 iniciar = 1'b0;
        busy = 0; conc = 0; err = 0; ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            err  += int'(erro_modo);
            conc += int'(concluido);
            if (habilita && {ch1, ch0} == 2'b11) chk("sel11_com_habilita", 1, 0);
            if (pronto) begin
                ok = 1;
                break;
            end
            busy++;
            passo = (busy - 1 < n_ef) ? busy - 1 : n_ef;
            chk("valor_ciclo", valor, modelo_valor(v0, m, s, passo, c));
            if (habilita) chk("sel_ativo", {ch1, ch0}, m);
        end
        if (!ok) chk("timeout_pronto", 0, 1);
        chk("ciclos_ocupado", busy, e_busy);
        chk("concluido_pulsos", conc, (m == 2'b11) ? 0 : 1);
        chk("erro_modo_pulsos", err, (m == 2'b11) ? 1 : 0);
        vm = modelo_valor(v0, m, s, n_ef, c);
        sm = modelo_saida(v0, m, s, n_ef, sm);
        chk("valor_final", valor, vm);
        chk("saida_serial", saida_serial, sm);
    endtask

    initial begin
        int busy, conc;
        bit ok;
        tab[0] = '{2'b00, 4'd0,  8'hA5, 1'b0, 8'hA5, 1'b0, 2};
        tab[1] = '{2'b01, 4'd3,  8'h00, 1'b1, 8'h2F, 1'b1, 4};
        tab[2] = '{2'b10, 4'd2,  8'h00, 1'b0, 8'h0B, 1'b1, 3};
        tab[3] = '{2'b11, 4'd5,  8'h00, 1'b0, 8'h0B, 1'b1, 0};
        tab[4] = '{2'b01, 4'd0,  8'h00, 1'b1, 8'h0B, 1'b1, 1};
        tab[5] = '{2'b10, 4'd15, 8'h00, 1'b1, 8'hFF, 1'b1, 16};
        tab[6] = '{2'b00, 4'd0,  8'h3C, 1'b0, 8'h3C, 1'b1, 2};
        tab[7] = '{2'b01, 4'd1,  8'h00, 1'b0, 8'h78, 1'b0, 2};

        // Reset held two cycles with a competing load request: reset must win
        reset = 1'b1; iniciar = 1'b1; modo = 2'b00; passos = 4'd0;
        valor_carga = 8'hFF; entrada_serial = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        iniciar = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("reset_valor", valor, 8'h00);
        chk("reset_pronto", pronto, 1);
        chk("reset_sel", {ch1, ch0}, 2'b11);
        chk("reset_concluido", concluido, 0);
        chk("reset_habilita", habilita, 0);
        chk("reset_saida", saida_serial, 0);
        chk("reset_erro", erro_modo, 0);
        vm = 8'h00; sm = 1'b0;

        for (int i = 0; i < 8; i++) begin
            executa(tab[i].m, tab[i].n, tab[i].c, tab[i].s, busy);
            chk($sformatf("tab%0d_valor", i), valor, tab[i].ev);
            chk($sformatf("tab%0d_saida", i), saida_serial, tab[i].es);
            chk($sformatf("tab%0d_ciclos", i), busy, tab[i].eb);
        end

        // iniciar held during a shift must be dropped, not queued
        @(negedge clk);
        iniciar = 1'b1; modo = 2'b10; passos = 4'd4; entrada_serial = 1'b0;
        @(posedge clk);
        #1 modo = 2'b00; valor_carga = 8'h55;
        busy = 0; ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 2) iniciar = 1'b0;
            if (pronto) begin
                ok = 1;
                break;
            end
            busy++;
        end
        if (!ok) chk("timeout_ignorado", 0, 1);
        chk("ignorado_ciclos", busy, 5);
        sm = modelo_saida(vm, 2'b10, 1'b0, 4, sm);
        vm = modelo_valor(vm, 2'b10, 1'b0, 4, 8'h00);
        repeat (3) @(negedge clk);
        chk("ignorado_valor", valor, vm);
        chk("ignorado_pronto", pronto, 1);

        // Reset in the middle of a shift aborts it without a completion pulse
        @(negedge clk);
        iniciar = 1'b1; modo = 2'b01; passos = 4'd6; entrada_serial = 1'b1;
        @(posedge clk);
        #1 iniciar = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_valor", valor, 8'h00);
        chk("abort_pronto", pronto, 1);
        chk("abort_sel", {ch1, ch0}, 2'b11);
        chk("abort_saida", saida_serial, 0);
        conc = 0;
        repeat (8) begin
            @(negedge clk);
            conc += int'(concluido);
        end
        chk("abort_sem_concluido", conc, 0);
        vm = 8'h00; sm = 1'b0;

        for (int r = 0; r < 40; r++) begin
            executa(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom),
                    1'($urandom), busy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
